up_sequencer: RTL and testbench

UP_SEQUENCER -- requirements
Module: up_sequencer

---
 rtl/up_sequencer_pkg.sv | 61 ++++++
 rtl/up_seq_decode.sv | 84 ++++++++
 rtl/up_sequencer.sv | 112 +++++++++++
 tb/tb_up_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/up_sequencer_pkg.sv
// Shared definitions for the up_sequencer control unit: opcodes, ALU/bus
// encodings, FSM states, memory timeout and the decoded control word.
package up_sequencer_pkg;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_NAND = 2'b10,
    ALU_CMP  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    BUS_OPRND = 2'b00,
    BUS_RAM   = 2'b01,
    BUS_PUSHB = 2'b10,
    BUS_ACCU  = 2'b11
  } bus_src_t;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'b00,
    ST_EXEC     = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  // Wait cycles spent in MEM_WAIT before the access is abandoned.
  localparam int unsigned WAIT_TIMEOUT = 15;

  // Write strobes here are unqualified; the top gates them with completion.
  typedef struct packed {
    logic     phase;
    logic     fetch_en;
    logic     pc_inc;
    logic     pc_load;
    alu_op_t  alu_op;
    bus_src_t bus_src;
    logic     acc_we;
    logic     flags_we;
    logic     ram_cs;
    logic     ram_we;
    logic     out_we;
    logic     mem;
  } ctrl_t;

endpackage

// File: rtl/up_seq_decode.sv
// Combinational state/opcode to control-word table for up_sequencer.
module up_seq_decode
  import up_sequencer_pkg::*;
(
  input  state_t      state,
  input  logic [3:0]  instr,
  input  logic        c_flag,
  input  logic        z_flag,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    if (state == ST_FETCH) begin
      ctrl.fetch_en = 1'b1;
      ctrl.pc_inc   = 1'b1;
    end else begin
      ctrl.phase = 1'b1;
      case (instr)
        OP_JC:    ctrl.pc_load = c_flag;
        OP_JNC:   ctrl.pc_load = ~c_flag;
        OP_JZ:    ctrl.pc_load = z_flag;
        OP_JNZ:   ctrl.pc_load = ~z_flag;
        OP_JMP:   ctrl.pc_load = 1'b1;
        OP_CMPI: begin
          ctrl.alu_op   = ALU_CMP;
          ctrl.flags_we = 1'b1;
        end
        OP_CMPM: begin
          ctrl.mem      = 1'b1;
          ctrl.ram_cs   = 1'b1;
          ctrl.bus_src  = BUS_RAM;
          ctrl.alu_op   = ALU_CMP;
          ctrl.flags_we = 1'b1;
        end
        OP_LIT:   ctrl.acc_we = 1'b1;
        OP_IN: begin
          ctrl.bus_src = BUS_PUSHB;
          ctrl.acc_we  = 1'b1;
        end
        OP_LD: begin
          ctrl.mem     = 1'b1;
          ctrl.ram_cs  = 1'b1;
          ctrl.bus_src = BUS_RAM;
          ctrl.acc_we  = 1'b1;
        end
        OP_ST: begin
          ctrl.mem     = 1'b1;
          ctrl.ram_cs  = 1'b1;
          ctrl.bus_src = BUS_ACCU;
          ctrl.ram_we  = 1'b1;
        end
        OP_ADDI: begin
          ctrl.alu_op   = ALU_ADD;
          ctrl.acc_we   = 1'b1;
          ctrl.flags_we = 1'b1;
        end
        OP_ADDM: begin
          ctrl.mem      = 1'b1;
          ctrl.ram_cs   = 1'b1;
          ctrl.bus_src  = BUS_RAM;
          ctrl.alu_op   = ALU_ADD;
          ctrl.acc_we   = 1'b1;
          ctrl.flags_we = 1'b1;
        end
        OP_OUT:   ctrl.out_we = 1'b1;
        OP_NANDI: begin
          ctrl.alu_op   = ALU_NAND;
          ctrl.acc_we   = 1'b1;
          ctrl.flags_we = 1'b1;
        end
        OP_NANDM: begin
          ctrl.mem      = 1'b1;
          ctrl.ram_cs   = 1'b1;
          ctrl.bus_src  = BUS_RAM;
          ctrl.alu_op   = ALU_NAND;
          ctrl.acc_we   = 1'b1;
          ctrl.flags_we = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/up_sequencer.sv
// Fetch/execute sequencer with flags and optional RAM wait handshake.
// Define UP_SEQ_WAIT_EN to enable MEM_WAIT, the ram_ready handshake and timeout.
module up_sequencer
  import up_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] instr,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       ram_ready,
  output logic       phase,
  output logic       fetch_en,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [1:0] alu_op,
  output logic [1:0] bus_src,
  output logic       acc_we,
  output logic       flags_we,
  output logic       ram_cs,
  output logic       ram_we,
  output logic       out_we,
  output logic       c_flag,
  output logic       z_flag,
  output logic       bus_err
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   done;
  logic   timeout;

  up_seq_decode u_decode (
    .state  (state),
    .instr  (instr),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .ctrl   (ctrl)
  );

`ifdef UP_SEQ_WAIT_EN
  logic [3:0] wait_cnt;
  logic       bus_err_q;

  assign done    = ~ctrl.mem | ram_ready;
  assign timeout = (state == ST_MEM_WAIT) && !ram_ready &&
                   (wait_cnt == 4'(WAIT_TIMEOUT - 1));

  // Counter is zeroed during EXEC, so it reads 0 on the first MEM_WAIT cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state == ST_EXEC)
        wait_cnt <= '0;
      else if (state == ST_MEM_WAIT && !ram_ready)
        wait_cnt <= wait_cnt + 4'd1;
      if (timeout)
        bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_sig;
  assign unused_sig = ram_ready ^ ctrl.mem;
  assign done       = 1'b1;
  assign timeout    = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset)
      state <= ST_FETCH;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    phase      = ctrl.phase;
    fetch_en   = ctrl.fetch_en;
    pc_inc     = ctrl.pc_inc;
    pc_load    = ctrl.pc_load;
    alu_op     = ctrl.alu_op;
    bus_src    = ctrl.bus_src;
    ram_cs     = ctrl.ram_cs;
    out_we     = ctrl.out_we;
    acc_we     = ctrl.acc_we & done;
    flags_we   = ctrl.flags_we & done;
    ram_we     = ctrl.ram_we & done;
    case (state)
      ST_FETCH:    state_next = ST_EXEC;
      ST_EXEC:     state_next = done ? ST_FETCH : ST_MEM_WAIT;
      ST_MEM_WAIT: if (done || timeout) state_next = ST_FETCH;
      default:     state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (flags_we) begin
      c_flag <= alu_c;
      z_flag <= alu_z;
    end
  end

endmodule

// File: tb/tb_up_sequencer.sv
// Randomized self-checking bench for up_sequencer; follows UP_SEQ_WAIT_EN
// to choose between the handshake and the single-cycle memory model.
module tb_up_sequencer;

`ifdef UP_SEQ_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] instr = '0;
  logic       alu_c = 1'b0;
  logic       alu_z = 1'b0;
  logic       ram_ready = 1'b0;
  logic       phase, fetch_en, pc_inc, pc_load;
  logic [1:0] alu_op, bus_src;
  logic       acc_we, flags_we, ram_cs, ram_we, out_we;
  logic       c_flag, z_flag, bus_err;

  always #5 clock = ~clock;

  up_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .instr     (instr),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .ram_ready (ram_ready),
    .phase     (phase),
    .fetch_en  (fetch_en),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .alu_op    (alu_op),
    .bus_src   (bus_src),
    .acc_we    (acc_we),
    .flags_we  (flags_we),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .out_we    (out_we),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .bus_err   (bus_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          model_c, model_z, model_err;

  logic [12:0] obs;
  assign obs = {phase, fetch_en, pc_inc, pc_load, alu_op, bus_src,
                acc_we, flags_we, ram_cs, ram_we, out_we};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] word(input bit ph, input bit fe, input bit inc, input bit ld,
                                       input bit [1:0] alu, input bit [1:0] bus,
                                       input bit acc, input bit flg, input bit cs,
                                       input bit we, input bit outw);
    return {ph, fe, inc, ld, alu, bus, acc, flg, cs, we, outw};
  endfunction

  function automatic bit is_mem(input bit [3:0] op);
    return op inside {4'h3, 4'h6, 4'h7, 4'hB, 4'hF};
  endfunction

  function automatic bit writes_flags(input bit [3:0] op);
    return op inside {4'h2, 4'h3, 4'hA, 4'hB, 4'hE, 4'hF};
  endfunction

  // Expected execute-phase word, from the opcode table and current model flags.
  function automatic logic [12:0] exp_exec(input bit [3:0] op, input bit done, input bit c, input bit z);
    bit       acc, taken;
    bit [1:0] alu, bus;
    acc = op inside {4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hE, 4'hF};
    if (op inside {4'h2, 4'h3})      alu = 2'b11;
    else if (op inside {4'hA, 4'hB}) alu = 2'b01;
    else if (op inside {4'hE, 4'hF}) alu = 2'b10;
    else                             alu = 2'b00;
    if (op == 4'h5)      bus = 2'b10;
    else if (op == 4'h7) bus = 2'b11;
    else if (is_mem(op)) bus = 2'b01;
    else                 bus = 2'b00;
    case (op)
      4'h0:    taken = c;
      4'h1:    taken = !c;
      4'h8:    taken = z;
      4'h9:    taken = !z;
      4'hC:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return word(1'b1, 1'b0, 1'b0, taken, alu, bus, acc && done, writes_flags(op) && done,
                is_mem(op), (op == 4'h7) && done, op == 4'hD);
  endfunction

  localparam logic [12:0] FETCH_WORD = 13'b0110_0000_00000;

  task automatic check_state(input string tag, input logic [12:0] exp);
    check_eq({tag, "/ctrl"}, 32'(obs), 32'(exp));
    check_eq({tag, "/flags"}, 32'({c_flag, z_flag}), 32'({model_c, model_z}));
    check_eq({tag, "/bus_err"}, 32'(bus_err), 32'(model_err));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ram_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_c = 1'b0;
    model_z = 1'b0;
    model_err = 1'b0;
    check_state("reset", FETCH_WORD);
  endtask

  // One full instruction: fetch cycle, then the execute/wait cycles.
  // ram_ready stays low for the first 'lag' execute-phase cycles.
  task automatic run_instr(input bit [3:0] op, input int unsigned lag, input bit c, input bit z);
    int unsigned n;
    bit          mem, rdy, done;
    mem = is_mem(op);
    n = (WAIT_EN && mem) ? ((lag <= 15) ? lag + 1 : 16) : 1;
    instr = op;
    alu_c = c;
    alu_z = z;
    ram_ready = (lag == 0);
    @(negedge clock);
    check_state($sformatf("op%0h/fetch", op), FETCH_WORD);
    @(posedge clock);
    #1;
    for (int unsigned k = 0; k < n; k++) begin
      rdy = (k >= lag);
      ram_ready = rdy;
      done = !mem || !WAIT_EN || rdy;
      @(negedge clock);
      check_state($sformatf("op%0h/exec%0d", op, k), exp_exec(op, done, model_c, model_z));
      @(posedge clock);
      #1;
      if (done && writes_flags(op)) begin
        model_c = c;
        model_z = z;
      end
      if (WAIT_EN && mem && k == 15 && !rdy)
        model_err = 1'b1;
    end
  endtask

  initial begin
    do_reset();
    run_instr(4'h4, 0, 1'b0, 1'b0);
    run_instr(4'h2, 0, 1'b1, 1'b1);
    run_instr(4'h8, 0, 1'b0, 1'b0);
    run_instr(4'hA, 0, 1'b0, 1'b0);
    run_instr(4'h1, 0, 1'b1, 1'b1);
    run_instr(4'h0, 0, 1'b1, 1'b1);
    run_instr(4'h6, 3, 1'b1, 1'b0);
    run_instr(4'h7, 20, 1'b0, 1'b0);
    run_instr(4'hC, 0, 1'b0, 1'b0);
    run_instr(4'hB, 15, 1'b1, 1'b0);
    run_instr(4'h3, 16, 1'b1, 1'b1);
    run_instr(4'h9, 0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 200; i++) begin
      bit [3:0]    op;
      int unsigned lag;
      op  = 4'($urandom_range(0, 15));
      lag = ($urandom_range(0, 9) == 0) ? 16 + $urandom_range(0, 2) : $urandom_range(0, 3);
      run_instr(op, lag, 1'($urandom), 1'($urandom));
    end

    // Reset arriving while a load is stalled (or, without the handshake, just after it).
    run_instr(4'h2, 0, 1'b1, 1'b1);
    instr = 4'h6;
    alu_c = 1'b0;
    alu_z = 1'b0;
    ram_ready = 1'b0;
    @(posedge clock);
    #1;
    check_eq("ld_norready/acc_we", 32'(acc_we), 32'(!WAIT_EN));
    @(posedge clock);
    #1;
    check_eq("midwait/ram_cs", 32'(ram_cs), 32'(WAIT_EN));
    check_eq("midwait/phase", 32'(phase), 32'(WAIT_EN));
    do_reset();
    run_instr(4'hD, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
